// File: rtl/pixel_line_scaler.sv
// Line-doubling pixel scaler: fetches one source line from flash into a line buffer,
// streams it to the display, and replays it for the following 2^s-1 display rows.
module pixel_line_scaler #(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned ADDR_W   = 24,
   parameter int unsigned CH_BITS  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         scale,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               frame_pulse,
   input  logic               row_pulse,
   input  logic [10:0]        row,
   input  logic [10:0]        col,
   input  logic               active,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_valid,
   output logic               start_read,
   output logic               stop_read,
   output logic [ADDR_W-1:0]  read_addr,
   output logic [CH_BITS-1:0] r,
   output logic [CH_BITS-1:0] g,
   output logic [CH_BITS-1:0] b,
   output logic               overrun
);

   localparam int unsigned IDX_W = $clog2(H_ACTIVE);
   localparam int unsigned CNT_W = $clog2(H_ACTIVE + 1);
   localparam int unsigned RGB_W = 3 * CH_BITS;
   localparam int unsigned G_HI  = 2 * PIX_W / 3 - 1;
   localparam int unsigned B_HI  = PIX_W / 3 - 1;
   localparam logic [ADDR_W-1:0] BYTES_PP = ADDR_W'(PIX_W / 8);
   localparam logic [10:0]       COL_LIM  = 11'(H_ACTIVE);

   typedef enum logic [1:0] {IDLE, FETCH, REPLAY} state_t;

   state_t             state_q, state_d;
   logic [1:0]         s_q, s_d;
   logic [ADDR_W-1:0]  addr_next_q, addr_next_d;
   logic [ADDR_W-1:0]  read_addr_d;
   logic [CNT_W-1:0]   wr_idx_q, wr_idx_d;
   logic               buf_valid_q, buf_valid_d;
   logic               start_pend_q, start_pend_d;
   logic               start_read_d, stop_read_d, overrun_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;

   logic [PIX_W-1:0]   line_buf [H_ACTIVE];
   logic               buf_we;
   logic [IDX_W-1:0]   buf_waddr;

   logic [1:0]         s_new, s_eff;
   logic [ADDR_W-1:0]  addr_eff;
   logic [CNT_W-1:0]   src_w, src_w_eff;
   logic [10:0]        row_mask, rd_col;
   logic [PIX_W-1:0]   rd_pix;
   logic               fetch_row_sel, pix_accept, fetch_done;

   function automatic logic [RGB_W-1:0] fields(input logic [PIX_W-1:0] p);
      return {p[PIX_W-1 -: CH_BITS], p[G_HI -: CH_BITS], p[B_HI -: CH_BITS]};
   endfunction

   // A frame strobe coinciding with a row strobe must see the new scale and base.
   assign s_new     = (scale == 2'd3) ? 2'd2 : scale;
   assign s_eff     = frame_pulse ? s_new : s_q;
   assign addr_eff  = frame_pulse ? base_addr : addr_next_q;
   assign src_w     = CNT_W'(H_ACTIVE >> s_q);
   assign src_w_eff = CNT_W'(H_ACTIVE >> s_eff);
   assign row_mask  = 11'((1 << s_eff) - 1);
   assign fetch_row_sel = (row & row_mask) == 11'd0;

   assign rd_col     = col >> s_q;
   assign rd_pix     = line_buf[IDX_W'(rd_col)];
   assign pix_accept = pix_valid && (state_q == FETCH) && (wr_idx_q < src_w);
   assign fetch_done = pix_accept && (wr_idx_q == src_w - CNT_W'(1));

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      addr_next_d  = addr_next_q;
      read_addr_d  = read_addr;
      wr_idx_d     = wr_idx_q;
      buf_valid_d  = buf_valid_q;
      start_pend_d = 1'b0;
      start_read_d = start_pend_q;
      stop_read_d  = 1'b0;
      overrun_d    = overrun;
      rgb_d        = rgb_q;
      buf_we       = 1'b0;
      buf_waddr    = IDX_W'(wr_idx_q);

      if (pix_valid) begin
         if (pix_accept) begin
            buf_we   = 1'b1;
            wr_idx_d = wr_idx_q + CNT_W'(1);
            rgb_d    = fields(pix_data);
            if (fetch_done) begin
               stop_read_d = 1'b1;
               buf_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (state_q == REPLAY) begin
         rgb_d = (buf_valid_q && (rd_col < COL_LIM)) ? fields(rd_pix) : '0;
      end
      if (!active) begin
         rgb_d = '0;
      end

      if (frame_pulse) begin
         s_d         = s_new;
         addr_next_d = base_addr;
      end

      if (row_pulse) begin
         if ((state_q == FETCH) && !fetch_done) begin
            stop_read_d = 1'b1;
            buf_valid_d = 1'b0;
         end
         if (fetch_row_sel) begin
            state_d      = FETCH;
            read_addr_d  = addr_eff;
            addr_next_d  = addr_eff + ADDR_W'(src_w_eff) * BYTES_PP;
            wr_idx_d     = '0;
            start_pend_d = 1'b1;
         end else begin
            state_d = REPLAY;
         end
      end

      // Flash handshake never sees start and stop together.
      if (stop_read_d) begin
         start_read_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         s_q          <= 2'd0;
         addr_next_q  <= '0;
         read_addr    <= '0;
         wr_idx_q     <= '0;
         buf_valid_q  <= 1'b0;
         start_pend_q <= 1'b0;
         start_read   <= 1'b0;
         stop_read    <= 1'b0;
         overrun      <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         addr_next_q  <= addr_next_d;
         read_addr    <= read_addr_d;
         wr_idx_q     <= wr_idx_d;
         buf_valid_q  <= buf_valid_d;
         start_pend_q <= start_pend_d;
         start_read   <= start_read_d;
         stop_read    <= stop_read_d;
         overrun      <= overrun_d;
         rgb_q        <= rgb_d;
      end
   end

   // Line buffer storage carries no reset; buf_valid_q guards its contents.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         line_buf[buf_waddr] <= pix_data;
      end
   end

   assign r = rgb_q[RGB_W-1 -: CH_BITS];
   assign g = rgb_q[2*CH_BITS-1 -: CH_BITS];
   assign b = rgb_q[CH_BITS-1 -: CH_BITS];

endmodule

// File: tb/tb_pixel_line_scaler.sv
// Self-checking bench for pixel_line_scaler: row-decision vector table, directed
// corner sequences, and randomized frames checked against a line-level model.
module tb_pixel_line_scaler;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned ADDR_W   = 24;
   localparam int unsigned CH_BITS  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        scale;
   logic [23:0]       base_addr;
   logic              frame_pulse, row_pulse, active, pix_valid;
   logic [10:0]       row, col;
   logic [7:0]        pix_data;
   logic              start_read, stop_read, overrun;
   logic [23:0]       read_addr;
   logic [1:0]        r, g, b;

   pixel_line_scaler #(
      .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W), .CH_BITS(CH_BITS)
   ) dut (
      .clk(clk), .rst(rst), .scale(scale), .base_addr(base_addr),
      .frame_pulse(frame_pulse), .row_pulse(row_pulse), .row(row), .col(col),
      .active(active), .pix_data(pix_data), .pix_valid(pix_valid),
      .start_read(start_read), .stop_read(stop_read), .read_addr(read_addr),
      .r(r), .g(g), .b(b), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sc;
      logic [10:0] rw;
      logic [23:0] base;
      logic        exp_stop;
      logic        exp_start;
      logic [23:0] exp_addr;
   } vec_t;

   vec_t        tbl [6];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_start  = 0;
   int          n_stop   = 0;
   int          n_both   = 0;
   logic [23:0] addr_q [$];

   // Line-level model: last completed source line, current shift, source width, next address.
   logic [7:0]  mline [H_ACTIVE];
   int          s_m;
   int          srcw_m;
   logic [23:0] addr_m;

   always @(negedge clk) begin
      if (start_read) begin
         n_start++;
         addr_q.push_back(read_addr);
      end
      if (stop_read) n_stop++;
      if (start_read && stop_read) n_both++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [5:0] fld(input logic [7:0] p);
      return {p[7:6], p[4:3], p[1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int sc, input logic [23:0] base);
      scale = 2'(sc); base_addr = base; frame_pulse = 1'b1;
      tick();
      frame_pulse = 1'b0;
      s_m    = (sc == 3) ? 2 : sc;
      srcw_m = H_ACTIVE >> s_m;
      addr_m = base;
   endtask

   task automatic fetch_row(input int rw, input int npix, input bit pat, input bit gaps);
      logic [7:0] d;
      logic [7:0] last;
      last = 8'h00;
      row = 11'(rw); row_pulse = 1'b1;
      tick();
      row_pulse = 1'b0;
      tick();
      check("fetch start_read", 32'(start_read), 32'd1);
      check("fetch read_addr", 32'(read_addr), 32'(addr_m));
      addr_m = addr_m + 24'(srcw_m);
      active = 1'b1;
      for (int i = 0; i < npix; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            tick();
            check("fetch hold rgb", 32'({r, g, b}), 32'(fld(last)));
         end
         d = pat ? 8'(i & 63) : 8'($urandom);
         pix_data = d; pix_valid = 1'b1;
         tick();
         check("fetch pixel rgb", 32'({r, g, b}), 32'(fld(d)));
         check("fetch stop timing", 32'(stop_read), 32'(i == srcw_m - 1));
         mline[i] = d;
         last = d;
      end
      pix_valid = 1'b0;
      if (npix == srcw_m) begin
         tick();
         check("stop one-shot", 32'(stop_read), 32'd0);
      end
   endtask

   task automatic replay_row(input int rw, input int ncols, input bit zero);
      int c;
      logic [5:0] e;
      row = 11'(rw); row_pulse = 1'b1;
      tick();
      row_pulse = 1'b0;
      for (int k = 0; k < ncols; k++) begin
         c = $urandom_range(0, H_ACTIVE - 1);
         col = 11'(c);
         active = ($urandom_range(0, 7) != 0);
         tick();
         e = (zero || !active) ? 6'd0 : fld(mline[c >> s_m]);
         check("replay rgb", 32'({r, g, b}), 32'(e));
         if (k == 0) check("replay no start_read", 32'(start_read), 32'd0);
      end
      active = 1'b1;
   endtask

   initial begin
      int ns0, nst0, r0;
      tbl[0] = '{2'd0, 11'd5, 24'h000100, 1'b0, 1'b1, 24'h000100};
      tbl[1] = '{2'd1, 11'd3, 24'h001000, 1'b1, 1'b0, 24'h000000};
      tbl[2] = '{2'd1, 11'd2, 24'h002000, 1'b0, 1'b1, 24'h002000};
      tbl[3] = '{2'd2, 11'd6, 24'h003000, 1'b1, 1'b0, 24'h000000};
      tbl[4] = '{2'd3, 11'd8, 24'hFFFF00, 1'b0, 1'b1, 24'hFFFF00};
      tbl[5] = '{2'd3, 11'd1, 24'h000200, 1'b1, 1'b0, 24'h000000};

      rst = 1'b1; scale = 2'd0; base_addr = '0; frame_pulse = 1'b0; row_pulse = 1'b0;
      row = '0; col = '0; active = 1'b1; pix_data = '0; pix_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("reset rgb", 32'({r, g, b}), 32'd0);
      check("reset start/stop/overrun", 32'({start_read, stop_read, overrun}), 32'd0);
      check("reset read_addr", 32'(read_addr), 32'd0);

      // Row decision with simultaneous frame strobe.
      for (int i = 0; i < 6; i++) begin
         scale = tbl[i].sc; row = tbl[i].rw; base_addr = tbl[i].base;
         frame_pulse = 1'b1; row_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0; row_pulse = 1'b0;
         check($sformatf("vec%0d stop_read", i), 32'(stop_read), 32'(tbl[i].exp_stop));
         check($sformatf("vec%0d early start", i), 32'(start_read), 32'd0);
         tick();
         check($sformatf("vec%0d start_read", i), 32'(start_read), 32'(tbl[i].exp_start));
         check($sformatf("vec%0d late stop", i), 32'(stop_read), 32'd0);
         if (tbl[i].exp_start) check($sformatf("vec%0d read_addr", i), 32'(read_addr), 32'(tbl[i].exp_addr));
      end

      // Three full-width rows at 1x from base 0x100.
      frame(0, 24'h000100);
      addr_q.delete();
      ns0 = n_stop; nst0 = n_start;
      fetch_row(0, 640, 1'b0, 1'b0);
      fetch_row(1, 640, 1'b0, 1'b1);
      fetch_row(2, 640, 1'b0, 1'b0);
      tick();
      check("1x stop count", 32'(n_stop - ns0), 32'd3);
      check("1x start count", 32'(n_start - nst0), 32'd3);
      check("1x addr count", 32'(addr_q.size()), 32'd3);
      check("1x addr row0", 32'(addr_q[0]), 32'h000100);
      check("1x addr row1", 32'(addr_q[1]), 32'h000380);
      check("1x addr row2", 32'(addr_q[2]), 32'h000600);

      // 2x: fetch a patterned line, then replay on the odd row.
      frame(1, 24'h040000);
      fetch_row(0, 320, 1'b1, 1'b0);
      row = 11'd1; row_pulse = 1'b1;
      tick();
      row_pulse = 1'b0; col = 11'd6; active = 1'b1;
      tick();
      check("2x col6 rgb", 32'({r, g, b}), 32'h03);
      check("2x replay no start", 32'(start_read), 32'd0);
      col = 11'd126;
      tick();
      check("2x col126 rgb", 32'({r, g, b}), 32'h0F);

      // Stray pixel during replay sets overrun and leaves the buffer alone.
      col = 11'd6; pix_data = 8'hFF; pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      check("overrun set", 32'(overrun), 32'd1);
      tick();
      check("replay after stray", 32'({r, g, b}), 32'h03);
      replay_row(3, 40, 1'b0);
      check("overrun sticky", 32'(overrun), 32'd1);

      // Abort a partial fetch, then the replay row shows zeros.
      frame(1, 24'h010000);
      fetch_row(0, 100, 1'b0, 1'b0);
      row = 11'd2; row_pulse = 1'b1;
      tick();
      row_pulse = 1'b0;
      check("abort stop_read", 32'(stop_read), 32'd1);
      check("abort no start yet", 32'(start_read), 32'd0);
      tick();
      check("restart start_read", 32'(start_read), 32'd1);
      check("restart stop clear", 32'(stop_read), 32'd0);
      check("restart read_addr", 32'(read_addr), 32'h010140);
      replay_row(3, 32, 1'b1);

      // Blanking overrides pixel data; reset mid-fetch clears everything.
      frame(0, 24'h000000);
      fetch_row(0, 2, 1'b0, 1'b0);
      active = 1'b0; pix_data = 8'hFF; pix_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("blank rgb", 32'({r, g, b}), 32'd0);
      end
      active = 1'b1;
      tick();
      check("unblank rgb", 32'({r, g, b}), 32'h3F);
      pix_valid = 1'b0;
      check("overrun before rst", 32'(overrun), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst rgb", 32'({r, g, b}), 32'd0);
      check("rst start/stop/overrun", 32'({start_read, stop_read, overrun}), 32'd0);
      check("rst read_addr", 32'(read_addr), 32'd0);
      tick();
      check("rst no stop", 32'({start_read, stop_read}), 32'd0);

      // Randomized frames against the line-level model.
      for (int t = 0; t < 4; t++) begin
         frame($urandom_range(0, 3), 24'($urandom));
         r0 = $urandom_range(0, 1000);
         for (int k = 0; k < 8; k++) begin
            if (((r0 + k) % (1 << s_m)) == 0) fetch_row(r0 + k, srcw_m, 1'b0, 1'b1);
            else replay_row(r0 + k, 40, 1'b0);
         end
      end

      tick();
      check("start/stop overlap", 32'(n_both), 32'd0);
      check("overrun clear", 32'(overrun), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
